calc1: RTL and testbench
========================

CALC1 -- requirements
Module: calc1

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 c_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  [1:7]  asynchronous, active-low; reset[1] low resets the whole block; reset[2:7] are ignored.
REQ-004 reqN_cmd_in  input  [0:3], N=1..4  per-port command; bit 0 is MSB.
REQ-005 reqN_data_in  input  [0:31], N=1..4  per-port operand; bit 0 is MSB.
REQ-006 out_dataN  output  [0:31], N=1..4  per-port result.
REQ-007 out_respN  output  [0:1], N=1..4  response: 0 none, 1 success, 2 error, 3 never driven.
REQ-008 Port order SHALL be: out_data1..4, out_resp1..4, c_clk, (req1_cmd_in, req1_data_in) .. (req4_cmd_in, req4_data_in), reset.

Function
REQ-009 Four ports SHALL operate independently and concurrently, each with its own state machine: IDLE, OP2, EXEC, RESP.
REQ-010 IDLE: a nonzero cmd SHALL capture cmd and data as operand1 and go to OP2; cmd 0 SHALL leave the port in IDLE.
REQ-011 OP2: the next cycle's reqN_data_in SHALL be captured as operand2 unconditionally; cmd in that cycle is ignored; go to EXEC.
REQ-012 EXEC SHALL last exactly 2 cycles, then go to RESP.
REQ-013 RESP SHALL last one cycle, with out_respN and out_dataN valid; then return to IDLE.
REQ-014 Latency: operand2 is captured at edge E; the response is visible for the single cycle following edge E+3.
REQ-015 Commands SHALL be ignored while the port is in OP2, EXEC or RESP; the requester waits for a nonzero response.
REQ-016 Commands: 1 add, 2 subtract, 5 shift left, 6 shift right; all others are invalid.
REQ-017 Add: 32-bit unsigned operand1+operand2; a carry out of bit 0 SHALL give resp 2 with data 0, otherwise resp 1 with the sum.
REQ-018 Subtract: operand1-operand2; operand2>operand1 SHALL give resp 2 with data 0, otherwise resp 1 with the difference.
REQ-019 Shift: operand1 is shifted logically by operand2[27:31] (0..31), zero-fill, resp 1.
REQ-020 Invalid command SHALL give resp 2 with data 0, with the same latency as a valid command.
REQ-021 Outside RESP, out_respN SHALL be 0 and out_dataN SHALL be 0; all outputs SHALL be registered.

Reset
REQ-022 reset[1]=0 SHALL asynchronously force all ports to IDLE and all out_data/out_resp to 0.
REQ-023 Reset mid-operation SHALL abort all in-flight commands with no response; reset release SHALL be synchronized to c_clk.
REQ-024 The first command SHALL be accepted on the first rising edge after reset deassertion.

Configuration
REQ-025 Macro CALC1_SHIFT_EN: when defined, commands 5 and 6 operate per REQ-019.
REQ-026 Without CALC1_SHIFT_EN, commands 5 and 6 SHALL be invalid (resp 2, data 0) and no shifter logic is built.

Verification
REQ-027 Port1: cmd 1, data 0x00000001, then 0x1FFFFFFF -> resp 1, data 0x20000000, 4 cycles after operand2.
REQ-028 Port1: cmd 1, data 0xFFFFFFFF, then 0x00000001 -> resp 2, data 0 (overflow).
REQ-029 Port1: cmd 2, data 0x00000001, then 0x0000000F -> resp 2, data 0 (underflow); cmd 2, 0x0F then 0x01 -> resp 1, data 0x0E.
REQ-030 Port1: cmd 3, cmd 4 and cmd 15 -> resp 2, data 0 each; port stays responsive.
REQ-031 With CALC1_SHIFT_EN: cmd 5, data 0x00000001, then 4 -> resp 1, data 0x10; cmd 6, data 0x80000000, then 31 -> resp 1, data 0x1. Without the macro, both -> resp 2.
REQ-032 All four ports issue add 1+1 simultaneously -> all four give resp 1, data 2 in the same cycle; reset asserted during EXEC -> no response and outputs 0.

Source files
------------

// File: rtl/calc1.sv
// Four-port calculator: each port runs an independent IDLE/OP2/EXEC/RESP machine.
// Optional shifter (cmd 5/6) is built only when CALC1_SHIFT_EN is defined.

module calc1_port (
  input  logic        c_clk,
  input  logic        rst_n,
  input  logic [3:0]  cmd_in,
  input  logic [31:0] data_in,
  output logic [31:0] out_data,
  output logic [1:0]  out_resp
);
  typedef enum logic [1:0] {IDLE, OP2, EXEC, RESP} state_t;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        exec_cnt_q, exec_cnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_resp_q, out_resp_d;

  logic [32:0] sum;
  logic [31:0] res_data;
  logic [1:0]  res_resp;

  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    res_data = '0;
    res_resp = RESP_ERR;
    case (cmd_q)
      4'd1: if (!sum[32]) begin
        res_data = sum[31:0];
        res_resp = RESP_OK;
      end
      4'd2: if (op2_q <= op1_q) begin
        res_data = op1_q - op2_q;
        res_resp = RESP_OK;
      end
`ifdef CALC1_SHIFT_EN
      4'd5: begin
        res_data = op1_q << op2_q[4:0];
        res_resp = RESP_OK;
      end
      4'd6: begin
        res_data = op1_q >> op2_q[4:0];
        res_resp = RESP_OK;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    exec_cnt_d = exec_cnt_q;
    out_data_d = '0;
    out_resp_d = '0;
    case (state_q)
      IDLE: if (cmd_in != 4'd0) begin
        cmd_d   = cmd_in;
        op1_d   = data_in;
        state_d = OP2;
      end
      OP2: begin
        op2_d      = data_in;
        exec_cnt_d = 1'b0;
        state_d    = EXEC;
      end
      EXEC: begin
        exec_cnt_d = 1'b1;
        if (exec_cnt_q) state_d = RESP;
      end
      // Result lands in the output register, so it is visible the cycle after RESP.
      RESP: begin
        out_data_d = res_data;
        out_resp_d = res_resp;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      exec_cnt_q <= 1'b0;
      out_data_q <= '0;
      out_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      exec_cnt_q <= exec_cnt_d;
      out_data_q <= out_data_d;
      out_resp_q <= out_resp_d;
    end
  end

  assign out_data = out_data_q;
  assign out_resp = out_resp_q;
endmodule

module calc1 (
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4,
  input  logic        c_clk,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  input  logic [1:7]  reset
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][3:0]  lane_cmd;
  logic [NUM_LANES-1:0][31:0] lane_data;
  logic [NUM_LANES-1:0][31:0] lane_out_data;
  logic [NUM_LANES-1:0][1:0]  lane_out_resp;
  logic                       unused_reset;

  assign unused_reset = ^reset[2:7];

  assign lane_cmd[0]  = req1_cmd_in;
  assign lane_cmd[1]  = req2_cmd_in;
  assign lane_cmd[2]  = req3_cmd_in;
  assign lane_cmd[3]  = req4_cmd_in;
  assign lane_data[0] = req1_data_in;
  assign lane_data[1] = req2_data_in;
  assign lane_data[2] = req3_data_in;
  assign lane_data[3] = req4_data_in;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    calc1_port u_port (
      .c_clk    (c_clk),
      .rst_n    (reset[1]),
      .cmd_in   (lane_cmd[g]),
      .data_in  (lane_data[g]),
      .out_data (lane_out_data[g]),
      .out_resp (lane_out_resp[g])
    );
  end

  assign out_data1 = lane_out_data[0];
  assign out_data2 = lane_out_data[1];
  assign out_data3 = lane_out_data[2];
  assign out_data4 = lane_out_data[3];
  assign out_resp1 = lane_out_resp[0];
  assign out_resp2 = lane_out_resp[1];
  assign out_resp3 = lane_out_resp[2];
  assign out_resp4 = lane_out_resp[3];
endmodule

// File: tb/tb_calc1.sv
// Directed bench for calc1: expected responses are queued at issue time and
// matched (value and arrival cycle) when a port raises a nonzero response.
module tb_calc1;
  logic        c_clk = 1'b0;
  logic [1:7]  reset = 7'b0;
  logic [3:0]  cmd_tb  [4];
  logic [31:0] data_tb [4];
  logic [31:0] od [4];
  logic [1:0]  orsp [4];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {int port; int cyc; logic [1:0] resp; logic [31:0] data;} exp_t;
  exp_t sb [$];

  calc1 dut (
    .out_data1(od[0]), .out_data2(od[1]), .out_data3(od[2]), .out_data4(od[3]),
    .out_resp1(orsp[0]), .out_resp2(orsp[1]), .out_resp3(orsp[2]), .out_resp4(orsp[3]),
    .c_clk(c_clk),
    .req1_cmd_in(cmd_tb[0]), .req1_data_in(data_tb[0]),
    .req2_cmd_in(cmd_tb[1]), .req2_data_in(data_tb[1]),
    .req3_cmd_in(cmd_tb[2]), .req3_data_in(data_tb[2]),
    .req4_cmd_in(cmd_tb[3]), .req4_data_in(data_tb[3]),
    .reset(reset)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Scoreboard monitor: every nonzero response must match the oldest entry for its port.
  always @(negedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      if (orsp[p] !== 2'd0) begin
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].port == p) idx = i;
        checks++;
        assert (idx >= 0) else begin
          failures++;
          $error("FAIL unexpected_resp port%0d cyc=%0d resp=%0d data=%h, required no response", p + 1, cyc, orsp[p], od[p]);
        end
        if (idx >= 0) begin
          checks += 3;
          assert (orsp[p] === sb[idx].resp) else begin
            failures++;
            $error("FAIL resp port%0d got=%0d exp=%0d", p + 1, orsp[p], sb[idx].resp);
          end
          assert (od[p] === sb[idx].data) else begin
            failures++;
            $error("FAIL data port%0d got=%h exp=%h", p + 1, od[p], sb[idx].data);
          end
          assert (cyc === sb[idx].cyc) else begin
            failures++;
            $error("FAIL latency port%0d got_cyc=%0d exp_cyc=%0d", p + 1, cyc, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end else begin
        checks++;
        assert (od[p] === 32'h0) else begin
          failures++;
          $error("FAIL idle_data port%0d got=%h exp=00000000", p + 1, od[p]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after operand2 capture (port in EXEC).
  task automatic issue(input logic [3:0] mask, input logic [3:0] c, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [3:0] op2_cmd, input bit push,
                       input logic [1:0] er, input logic [31:0] ed);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin cmd_tb[p] = c; data_tb[p] = d1; end
    @(posedge c_clk);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin
        cmd_tb[p] = op2_cmd; data_tb[p] = d2;
        if (push) sb.push_back('{p, cyc + 4, er, ed});
      end
    @(posedge c_clk);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin cmd_tb[p] = 4'd0; data_tb[p] = 32'h0; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge c_clk); #1;
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout pending=%0d exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic check_outs_zero(input string tag);
    for (int p = 0; p < 4; p++) begin
      checks++;
      assert (orsp[p] === 2'd0 && od[p] === 32'h0) else begin
        failures++;
        $error("FAIL %s port%0d resp=%0d data=%h exp resp=0 data=00000000", tag, p + 1, orsp[p], od[p]);
      end
    end
  endtask

  initial begin
    logic [1:0]  sh_r;
    logic [31:0] sh_d1, sh_d2;
    for (int p = 0; p < 4; p++) begin cmd_tb[p] = 4'd0; data_tb[p] = 32'h0; end
    repeat (3) @(negedge c_clk);
    #1 check_outs_zero("reset_state");
    // Release away from the clock edge; the very next rising edge accepts a command.
    reset = 7'h7F;
    issue(4'b0001, 4'd1, 32'h00000001, 32'h1FFFFFFF, 4'd0, 1, 2'd1, 32'h20000000);
    drain();
    issue(4'b0001, 4'd1, 32'hFFFFFFFF, 32'h00000001, 4'd0, 1, 2'd2, 32'h0);
    drain();
    issue(4'b0001, 4'd2, 32'h00000001, 32'h0000000F, 4'd0, 1, 2'd2, 32'h0);
    drain();
    // Nonzero cmd during OP2 must be ignored.
    issue(4'b0001, 4'd2, 32'h0000000F, 32'h00000001, 4'd7, 1, 2'd1, 32'h0000000E);
    drain();
    issue(4'b0001, 4'd3, 32'h00000005, 32'h00000001, 4'd0, 1, 2'd2, 32'h0);
    drain();
    issue(4'b0001, 4'd4, 32'h00000005, 32'h00000001, 4'd0, 1, 2'd2, 32'h0);
    drain();
    issue(4'b0001, 4'd15, 32'h00000005, 32'h00000001, 4'd0, 1, 2'd2, 32'h0);
    drain();
`ifdef CALC1_SHIFT_EN
    sh_r = 2'd1; sh_d1 = 32'h10; sh_d2 = 32'h1;
`else
    sh_r = 2'd2; sh_d1 = 32'h0;  sh_d2 = 32'h0;
`endif
    issue(4'b0001, 4'd5, 32'h00000001, 32'd4, 4'd0, 1, sh_r, sh_d1);
    drain();
    issue(4'b0001, 4'd6, 32'h80000000, 32'd31, 4'd0, 1, sh_r, sh_d2);
    drain();
    issue(4'b0001, 4'd1, 32'h00000001, 32'h00000001, 4'd0, 1, 2'd1, 32'h2);
    drain();
    issue(4'b0100, 4'd2, 32'h00000010, 32'h00000010, 4'd0, 1, 2'd1, 32'h0);
    drain();
    issue(4'b1000, 4'd1, 32'hFFFFFFFE, 32'h00000001, 4'd0, 1, 2'd1, 32'hFFFFFFFF);
    drain();
    issue(4'b1111, 4'd1, 32'h00000001, 32'h00000001, 4'd0, 1, 2'd1, 32'h2);
    drain();
    // Abort all four ports mid-EXEC; no response may ever appear for them.
    issue(4'b1111, 4'd1, 32'h00000001, 32'h00000001, 4'd0, 0, 2'd0, 32'h0);
    #1 reset = 7'h00;
    #1 check_outs_zero("reset_mid_exec");
    repeat (2) @(negedge c_clk);
    #1 check_outs_zero("reset_hold");
    reset = 7'h7F;
    issue(4'b0010, 4'd1, 32'h00000003, 32'h00000004, 4'd0, 1, 2'd1, 32'h7);
    drain();
    repeat (6) @(negedge c_clk);
    #1 check_outs_zero("post_abort_quiet");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
